// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_pkg
// Description : Operation codes and FSM states for the multiply/divide unit.
// Revision    : 1.0
// ============================================================================
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_if
// Description : Issue/result bundle between the execute-stage controller and the unit.
// Revision    : 1.0
// ============================================================================
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    import alu_muldiv_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    md_op_e           md_op;
    logic             start;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, md_op, start,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  a, b, md_op, start,
        output busy, done, div_by_zero, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/alu_muldiv_md_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : md_iter_step
// Description : One shift-add multiply or restoring-divide iteration on magnitudes.
// Revision    : 1.0
// ============================================================================
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [2*WIDTH-1:0] i_acc,
    input  wire logic [WIDTH-1:0]   i_operand,
    input  wire logic               i_is_div,
    output logic      [2*WIDTH-1:0] o_acc_next,
    output logic                    o_q_bit
);

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_partial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    assign w_partial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    assign w_ge      = (w_partial >= {1'b0, i_operand});
    // When the subtraction is taken the result is below the divisor, so W bits suffice.
    assign w_diff    = w_partial[WIDTH-1:0] - i_operand;

    always_comb begin
        o_acc_next = {w_mul_sum, i_acc[WIDTH-1:1]};
        o_q_bit    = 1'b0;
        if (i_is_div) begin
            o_q_bit    = w_ge;
            o_acc_next = {(w_ge ? w_diff : w_partial[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Iterative MULT/MULTU/DIV/DIVU unit with the HI/LO register pair.
// Revision    : 1.0
// ============================================================================
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_muldiv_if.slave bus
);

    md_state_e          r_state;
    md_state_e          w_state_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_dz_flag;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_iter_op;
    logic               w_signed;
    logic               w_div;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_last;

    assign w_accept  = (r_state == S_IDLE) && bus.start;
    assign w_signed  = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
    assign w_div     = (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);
    assign w_iter_op = w_div || (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);
    assign w_sa      = w_signed & bus.a[WIDTH-1];
    assign w_sb      = w_signed & bus.b[WIDTH-1];
    assign w_mag_a   = w_sa ? -bus.a : bus.a;
    assign w_mag_b   = w_sb ? -bus.b : bus.b;
    assign w_last    = (r_cnt == CNT_W'(1));

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_acc      (r_acc),
        .i_operand  (r_operand),
        .i_is_div   (r_is_div),
        .o_acc_next (w_step_acc),
        .o_q_bit    (w_q_bit)
    );

    assign w_acc_next = {w_step_acc[2*WIDTH-1:1], w_step_acc[0] | w_q_bit};
    assign w_prod     = r_neg_q ? -w_acc_next : w_acc_next;
    assign w_quo      = r_neg_q ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
    assign w_rem      = r_neg_r ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];

    // A zero divisor bypasses the sign fix: the raw path yields all-ones / dividend.
    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_res_hi = w_acc_next[2*WIDTH-1:WIDTH];
                w_res_lo = w_acc_next[WIDTH-1:0];
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_iter_op) w_state_next = S_RUN;
            S_RUN:    if (w_last) w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_dz_flag <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (bus.md_op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                r_acc     <= {{WIDTH{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
                                r_operand <= w_div ? w_mag_b : w_mag_a;
                                r_cnt     <= CNT_W'(WIDTH);
                                r_is_div  <= w_div;
                                r_neg_q   <= w_sa ^ w_sb;
                                r_neg_r   <= w_sa;
                                r_dz      <= w_div && (bus.b == '0);
                                r_dz_flag <= 1'b0;
                            end
                            MD_MTHI: begin
                                r_hi      <= bus.a;
                                r_dz_flag <= 1'b0;
                            end
                            MD_MTLO: begin
                                r_lo      <= bus.a;
                                r_dz_flag <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Results land on the edge into FINISH so they are visible with DONE.
                    if (w_last) begin
                        r_hi      <= w_res_hi;
                        r_lo      <= w_res_lo;
                        r_dz_flag <= r_is_div & r_dz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_FINISH);
    assign bus.div_by_zero = r_dz_flag;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Directed self-checking bench for alu_muldiv (WIDTH = 32).
// Revision    : 1.0
// ============================================================================
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_muldiv_if #(.WIDTH(32)) bus ();

    alu_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the op's final DONE cycle.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int lat;
        int nbusy;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat   = 1;
        nbusy = 0;
        check({tag, "_busy_t1"}, 64'(bus.busy), 64'd1);
        check({tag, "_dz_cleared"}, 64'(bus.div_by_zero), 64'd0);
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy === 1'b1) nbusy++;
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'd33);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(exp_dz));
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_done_after"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int  cyc;
        logic saw_done;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.md_op = MD_NOP;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_dz",   64'(bus.div_by_zero), 64'd0);
        check("reset_hi",   64'(bus.hi), 64'd0);
        check("reset_lo",   64'(bus.lo), 64'd0);

        run_op("mult_neg3x5",   MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("multu_max_x2",  MD_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("divu_100_7",    MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0);
        run_op("div_neg7_2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf",       MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0);
        run_op("divu_by_zero",  MD_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        check("dz_sticky", 64'(bus.div_by_zero), 64'd1);
        run_op("multu_3x4",     MD_MULTU, 32'd3,         32'd4,        32'd0,         32'd12,        1'b0);

        // MTHI sets a known HI, then a MTHI issued mid-MULT must be ignored.
        bus.md_op = MD_MTHI;
        bus.a     = 32'h1111_1111;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("mthi_hi",   64'(bus.hi), 64'h1111_1111);
        check("mthi_done", 64'(bus.done), 64'd0);
        check("mthi_busy", 64'(bus.busy), 64'd0);

        bus.md_op = MD_MULT;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.md_op = MD_MTHI;
        bus.a     = 32'h0000_AAAA;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_mthi_ignored_hi", 64'(bus.hi), 64'h1111_1111);
        check("busy_mthi_still_busy", 64'(bus.busy), 64'd1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("mult_2x3_done", 64'(bus.done), 64'd1);
        check("mult_2x3_hi",   64'(bus.hi), 64'd0);
        check("mult_2x3_lo",   64'(bus.lo), 64'd6);
        @(negedge clk);

        bus.md_op = MD_MTLO;
        bus.a     = 32'h0000_0055;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_lo",   64'(bus.lo), 64'h55);
        check("mtlo_done", 64'(bus.done), 64'd0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of a divide.
        bus.md_op = MD_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hi",   64'(bus.hi), 64'd0);
        check("rst_mid_lo",   64'(bus.lo), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_done", 64'(saw_done), 64'd0);

        run_op("mult_6x7", MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle multiply/divide unit that extends the combinational ALU with MIPS MULT/MULTU/DIV/DIVU and the HI/LO register pair.
- Sits beside the ALU in the execute stage. Operands A and B come from the register-file read ports.
- The controller issues an op with START and stalls the pipeline while BUSY. HI and LO are always readable, which serves MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- A  in  WIDTH  multiplicand or dividend; source for MTHI/MTLO.
- B  in  WIDTH  multiplier or divisor.
- MD_OP  in  3  operation select (`MD_* constants).
- START  in  1  issue strobe; sampled only in IDLE.
- BUSY  out  1  high while an iterative op is in flight (RUN or FINISH).
- DONE  out  1  single-cycle pulse; HI/LO hold the new result in this cycle.
- DIV_BY_ZERO  out  1  sticky flag; cleared by the next accepted START or by RST.
- HI  out  WIDTH  HI register (product upper half or remainder).
- LO  out  WIDTH  LO register (product lower half or quotient).

Behaviour:
- Reset: synchronous, active-high on the rising edge of CLK. Outputs after reset: BUSY=0, DONE=0, DIV_BY_ZERO=0, HI=0, LO=0; state returns to IDLE.
- Reset mid-operation: RST wins over everything. The op is aborted, no DONE pulse, HI/LO cleared.
- Op encoding: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- States: IDLE, RUN, FINISH.
- IDLE, START=1, op MULT/MULTU/DIV/DIVU (edge t):
  - latch |A| and |B| for signed ops, raw values for unsigned ops;
  - latch the sign-fix flags; load counter = WIDTH;
  - go to RUN. BUSY=1 from cycle t+1.
- IDLE, START=1, op MTHI/MTLO: write A into HI or LO at the same edge. Single cycle, no BUSY, no DONE.
- IDLE, START=1, op NOP or reserved: no effect.
- RUN, multiply: radix-2 shift-add, one bit per cycle. Accumulator is 2*WIDTH bits, unsigned magnitudes.
- RUN, divide: restoring division, one quotient bit per cycle, unsigned magnitudes.
- RUN exit: counter decrements each cycle; RUN lasts exactly WIDTH cycles, then go to FINISH.
- FINISH (one cycle):
  - apply sign fix: product negated if sign(A) xor sign(B); quotient negated if signs differ; remainder takes the sign of A;
  - write HI/LO; DONE=1; BUSY=1;
  - next state is IDLE.
- Latency: START accepted at edge t; DONE is high in cycle t+WIDTH+1 (33 for WIDTH=32); BUSY is low again in cycle t+WIDTH+2.
- Divide by zero (B=0, DIV or DIVU):
  - full latency still runs;
  - result is LO = all ones, HI = A (unsigned magnitude path, no sign fix);
  - DIV_BY_ZERO set in the DONE cycle.
- Signed overflow: DIV of the most-negative value by -1 gives LO = most-negative value, HI = 0. This is the natural two's-complement wrap; no flag is raised.
- START while BUSY (RUN or FINISH): ignored, including MTHI/MTLO. The controller is required to hold the request until BUSY=0.
- HI/LO hold their previous values throughout RUN. They change only in FINISH, on MTHI/MTLO, or on RST.

Decomposition:
- Shared constants go in controller_constants.vh: `MD_NOP, `MD_MULT, `MD_MULTU, `MD_DIV, `MD_DIVU, `MD_MTHI, `MD_MTLO (3-bit), alongside the existing `ALU_* codes.
- One sub-module, md_iter_step: combinational single-iteration datapath.
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator and quotient bit.
- Parent alu_muldiv owns the FSM, the counter, the sign fix and the HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> DONE at t+33; HI=0xFFFFFFFF, LO=0xFFFFFFF1; BUSY high cycles t+1..t+33.
- MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE. DIVU A=100, B=7 -> LO=14, HI=2.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 -> DONE at t+33; LO=0xFFFFFFFF, HI=0x1234, DIV_BY_ZERO=1. Next accepted START clears the flag.
- Issue MULT; pulse START with MTHI A=0xAAAA at t+5 -> ignored; HI unchanged until FINISH. After BUSY=0, MTLO A=0x55 -> LO=0x55 next edge, no DONE.
- Issue DIV; assert RST at t+10 -> next cycle BUSY=0, HI=LO=0, no DONE pulse ever. A fresh MULT 6*7 afterwards -> LO=42, HI=0.
